// File: rtl/adc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// adc_frame_sequencer
//
// Captures fixed-length frames from the bias-corrected ADC stream for the
// FFT/separation path. On start it discards SETTLE_LEN raw samples, then takes
// every decim-th sample until FRAME_LEN samples have been taken, presenting
// them on a single-register valid/ready output. Samples that arrive while the
// output word is stalled are dropped (overrun), but frame timing is preserved.
//
// Ports:
//   clk, rst          clock (one ADC sample per cycle), async active-high reset
//   adc_data          signed DW-bit sample, new every cycle
//   start, abort      single-cycle control pulses (abort wins over start)
//   continuous        re-arm after each frame without a settle window
//   decim             decimation factor, latched at start (0 behaves as 1)
//   m_data/m_valid/m_last/m_ready   output stream, m_last marks frame end
//   busy              high in SETTLE or CAPTURE
//   frame_done        one-cycle pulse after the last word of a frame is accepted
//   overrun           sticky: a decimated sample was lost (cleared by start)
//   peak              max |sample| of the last completed frame (saturating)
// -----------------------------------------------------------------------------
module adc_frame_sequencer #(
  parameter int DW         = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int SETTLE_LEN = 16,
  parameter int CW         = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] adc_data,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic [7:0]           decim,
  output logic signed [DW-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [DW-2:0]        peak
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
  localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [DW-2:0] MAG_MAX     = '1;

  // Magnitude of a two's-complement sample; the most negative code has no
  // positive counterpart and saturates to the largest magnitude.
  function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] neg;
    neg = -x;
    if (!x[DW-1]) return x[DW-2:0];
    if (neg[DW-1]) return MAG_MAX;
    return neg[DW-2:0];
  endfunction

  function automatic logic [DW-2:0] max_mag(input logic [DW-2:0] a,
                                            input logic [DW-2:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        settle_cnt_q;
  logic [CW-1:0]        samp_cnt_q;
  logic [7:0]           dec_cnt_q;
  logic [7:0]           decim_q;
  logic [DW-2:0]        run_peak_q;
  logic [DW-2:0]        done_peak_q;

  logic signed [DW-1:0] data_p1;
  logic                 vld_p1;
  logic                 last_p1;

  logic                 start_ok;
  logic                 take;
  logic                 last_take;
  logic                 accept;
  logic                 load;
  logic                 drop;
  logic                 done_acc;
  logic [DW-2:0]        run_peak_nxt;

  // ---------------------------------------------------------------------------
  // Stage p0: state decode, sample selection, output-register arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    start_ok     = 1'b0;
    take         = 1'b0;
    last_take    = 1'b0;
    accept       = vld_p1 & m_ready;
    load         = 1'b0;
    drop         = 1'b0;
    done_acc     = 1'b0;
    run_peak_nxt = run_peak_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_ok = 1'b1;
          state_d  = (SETTLE_LEN == 0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        take      = (dec_cnt_q == 8'd0);
        last_take = take && (samp_cnt_q == FRAME_LAST);
        if (last_take && !continuous) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      take      = 1'b0;
      last_take = 1'b0;
    end

    // A taken sample only fits if the output word is empty or leaving now.
    load     = take & (~vld_p1 | accept);
    drop     = take & ~load;
    done_acc = accept & last_p1 & ~abort;

    if (load) run_peak_nxt = max_mag(run_peak_q, abs_sat(adc_data));
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: control state, counters, status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      dec_cnt_q    <= 8'd0;
      decim_q      <= 8'd1;
      run_peak_q   <= '0;
      done_peak_q  <= '0;
      overrun      <= 1'b0;
      frame_done   <= 1'b0;
      peak         <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        decim_q      <= (decim == 8'd0) ? 8'd1 : decim;
        settle_cnt_q <= '0;
        samp_cnt_q   <= '0;
        dec_cnt_q    <= 8'd0;
        run_peak_q   <= '0;
        overrun      <= 1'b0;
      end else begin
        if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q + CW'(1);

        if (state_q == CAPTURE && !abort) begin
          if (last_take) begin
            // Frame boundary: snapshot the finished frame's peak so the
            // next frame can start accumulating immediately.
            samp_cnt_q  <= '0;
            dec_cnt_q   <= 8'd0;
            run_peak_q  <= '0;
            done_peak_q <= run_peak_nxt;
          end else begin
            if (take) samp_cnt_q <= samp_cnt_q + CW'(1);
            dec_cnt_q  <= (dec_cnt_q >= decim_q - 8'd1) ? 8'd0 : dec_cnt_q + 8'd1;
            run_peak_q <= run_peak_nxt;
          end
        end

        if (drop) overrun <= 1'b1;
      end

      frame_done <= done_acc;
      if (done_acc) peak <= done_peak_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (abort) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      data_p1 <= adc_data;
      vld_p1  <= 1'b1;
      last_p1 <= last_take;
    end else if (accept) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (drop && last_take) begin
      // The frame's final sample was lost; the stalled word closes the frame.
      last_p1 <= 1'b1;
    end
  end

  assign m_data  = data_p1;
  assign m_valid = vld_p1;
  assign m_last  = last_p1;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Sequences capture of fixed-length sample frames from the bias-corrected ADC stream for the downstream FFT/separation path.
- On a start request it discards a settling window of samples, then decimates the stream.
- It emits exactly FRAME_LEN samples over a valid/ready interface, marking the last sample of each frame.
- It reports frame completion, overrun and the per-frame peak magnitude.
- It sits between the ADC front-end and the FFT input buffer, and is driven by the system control FSM.

Parameters:
DW, 10, sample width; two's-complement, already bias-corrected.
FRAME_LEN, 1024, samples per frame; must be at least 2.
SETTLE_LEN, 16, raw ADC samples discarded after start, before decimation begins; 0 allowed.
CW, 11, counter width; must satisfy 2^CW > max(FRAME_LEN, SETTLE_LEN).

Ports:
clk  in  1  system clock; the ADC sample rate, one sample per cycle.
rst  in  1  asynchronous reset, active-high.
adc_data  in  DW  bias-corrected ADC sample, new value every cycle.
start  in  1  single-cycle pulse; arms a frame capture.
abort  in  1  single-cycle pulse; cancels the capture in progress.
continuous  in  1  when 1, re-arms automatically after each frame, with no settle window.
decim  in  8  decimation factor; 0 and 1 both mean keep every sample. Sampled at start only.
m_data  out  DW  output sample.
m_valid  out  1  output sample valid.
m_last  out  1  marks the final sample of a frame; qualified by m_valid.
m_ready  in  1  downstream accept.
busy  out  1  high in SETTLE or CAPTURE.
frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted.
overrun  out  1  sticky flag: a decimated sample was lost; cleared by start or rst.
peak  out  DW-1  maximum |sample| of the last completed frame; saturates at 2^(DW-1)-1.

Behaviour:
- Reset values:
  - State IDLE; all counters 0.
  - m_valid, m_last, frame_done, overrun and busy are 0.
  - m_data = 0, peak = 0, latched decim = 1.
- States: IDLE, SETTLE, CAPTURE.
- IDLE:
  - start -> SETTLE. If SETTLE_LEN == 0, start -> CAPTURE directly.
  - On start: latch decim (0 is treated as 1); clear overrun, the sample counter and the running peak.
- SETTLE:
  - Counts raw input cycles; after SETTLE_LEN cycles -> CAPTURE.
  - The first cycle in CAPTURE is the first candidate sample.
- CAPTURE:
  - A decimation counter runs 0..decim-1. The sample on the cycle where the counter is 0 is taken.
  - So the first sample is taken in the first CAPTURE cycle, then every decim-th cycle after it.
- Taking a sample:
  - If the output register is empty, or is being accepted this cycle (m_valid & m_ready): load m_data, set m_valid. The load is visible 1 cycle after the input cycle.
  - Otherwise: drop the sample and set overrun. The sample and frame counters still advance, so frame timing is preserved.
- m_last: set with the FRAME_LEN-th taken sample, whether that sample is loaded or dropped. If it is dropped, m_last is set on the held word instead.
- Running peak: updated from every taken and loaded sample.
  - |x| for the most negative value saturates to 2^(DW-1)-1.
- After the FRAME_LEN-th sample is taken:
  - continuous = 1: stay in CAPTURE; restart the frame counter, decimation phase and running peak.
  - continuous = 0: go to IDLE; the pending output word still drains.
- frame_done and peak update:
  - frame_done pulses on the cycle m_valid & m_ready & m_last (registered, 1 cycle later).
  - peak updates from the running peak at the same time.
- Output register rules:
  - Holds m_data/m_last stable while m_valid & !m_ready.
  - m_valid drops after acceptance unless a new sample loads in the same cycle.
- abort, in any state:
  - Next cycle: state IDLE; clear m_valid and m_last (the pending word is discarded).
  - No frame_done; overrun and peak are retained.
- Simultaneous start and abort: abort wins.
- start while busy is ignored.
- start in IDLE while a final word is still pending: accepted. The new frame's samples queue behind the pending word under the normal overrun rule.
- rst mid-frame: asynchronous return to the reset values.
- Counters never wrap within a frame; CW is sized by the parameter rule.

Test Plan:
- Single frame: FRAME_LEN=8, SETTLE_LEN=4, decim=1, m_ready=1, adc_data ramp 0,1,2... with start at cycle 0.
  -> 8 outputs, values 4..11 (first input taken is index 4).
  -> m_last on 11; one frame_done; peak=11; busy low after.
- Decimation: decim=3, same ramp, SETTLE_LEN=0.
  -> outputs 0,3,6,...,21; m_last on 21.
  -> decim=0 behaves exactly like decim=1.
- Backpressure: m_ready=0 for 5 cycles mid-frame, decim=1.
  -> m_data held stable and overrun=1.
  -> The frame still ends after the 8th taken sample, and the held word carries m_last.
  -> The next start clears overrun.
- Peak saturation: frame of samples including -512 and +300 (DW=10) -> peak=511.
- Continuous mode: continuous=1, FRAME_LEN=4.
  -> frame_done every 4 accepted samples, with no settle gap between frames.
  -> Deassert continuous: exactly one more frame completes, then IDLE.
- Abort/reset: abort in CAPTURE with m_valid=1 and m_ready=0.
  -> Next cycle m_valid=0, no frame_done, state IDLE.
  -> start+abort in the same cycle leaves the block IDLE.
  -> rst asserted mid-frame clears all outputs asynchronously, before the next clk edge.
